// File: rtl/fetch_queue_unit_pkg.sv
// Shared fetch-stage definitions.
// Holds the datapath width, instruction size, default reset PC, the NOP
// encoding used downstream for slot filling, the {pc, instr} fetch-entry
// type and a helper that word-aligns a byte address.
package fetch_queue_unit_pkg;

  localparam int          XLEN             = 32;
  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Instructions are word-aligned, so the low two address bits are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue_unit_fifo.sv
// fetch_fifo: synchronous FIFO of fetch entries.
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   flush        drops all entries (pointers and count cleared)
//   push, pop    write/read strobes; push while full is legal when pop is set
//   wr_data      entry written at the write pointer on push
//   rd_data      entry at the read pointer (raw, not gated by occupancy)
//   count        current occupancy, 0..DEPTH
module fetch_fifo
  import fetch_queue_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               push,
  input  logic               pop,
  input  fetch_entry_t       wr_data,
  output fetch_entry_t       rd_data,
  output logic [CNT_W-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: the storage array has no reset; occupancy is tracked by the count,
  // so stale contents are never observed and the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) r_mem[r_wr_ptr] <= wr_data;
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign count   = r_count;

endmodule

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: fetch stage in front of an asynchronous instruction ROM.
// Owns the fetch PC, captures the ROM word in the same cycle and queues
// {pc, instr} pairs for the downstream decode over a valid/ready handshake.
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   imem_addr / imem_data    ROM byte address (= fetch PC) and its read data
//   redirect_valid/_pc       flush the queue and restart fetch at redirect_pc
//   out_valid/_ready         head-entry handshake
//   out_instr, out_pc        head entry, forced to 0 while the queue is empty
//   fq_count                 queue occupancy
module fetch_queue_unit
  import fetch_queue_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          FQ_DEPTH = 4,                    // power of two, >= 2
  parameter int          CNT_W    = $clog2(FQ_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [31:0]       imem_addr,
  input  logic [31:0]       imem_data,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc,
  output logic [CNT_W-1:0]  fq_count
);

  logic [31:0]      r_fetch_pc;
  logic             w_push;
  logic             w_pop;
  logic             w_valid;
  logic [CNT_W-1:0] w_count;
  fetch_entry_t     w_wr_entry;
  fetch_entry_t     w_head;

  assign w_valid = (w_count != '0);
  assign w_pop   = w_valid & out_ready;
  // A full queue still accepts the fetch when the head leaves this cycle.
  assign w_push  = !redirect_valid & ((w_count < CNT_W'(FQ_DEPTH)) | w_pop);

  assign w_wr_entry.pc    = r_fetch_pc;
  assign w_wr_entry.instr = imem_data;

  // Reset beats redirect, and redirect beats the sequential advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= align_pc(RESET_PC);
    end else if (redirect_valid) begin
      r_fetch_pc <= align_pc(redirect_pc);
    end else if (w_push) begin
      r_fetch_pc <= r_fetch_pc + 32'(INSTR_BYTES);  // wraps modulo 2^32
    end
  end

  fetch_fifo #(
    .DEPTH (FQ_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (redirect_valid),
    .push    (w_push),
    .pop     (w_pop),
    .wr_data (w_wr_entry),
    .rd_data (w_head),
    .count   (w_count)
  );

  // The ROM address is the PC register alone, so no loop forms through the
  // combinational ROM back into push/pop.
  assign imem_addr = r_fetch_pc;
  assign fq_count  = w_count;
  assign out_valid = w_valid;

  // NOTE: every output of this always_comb is given a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    out_pc    = '0;
    out_instr = '0;
    if (w_valid) begin
      out_pc    = w_head.pc;
      out_instr = w_head.instr;
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed testbench for fetch_queue_unit. Two instances: the default one
// (RESET_PC = 0) and one reset near the top of the address space to exercise
// PC wrap-around. ROM model: word n holds 32'hA000_0000 + n.
module tb_fetch_queue_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_ready;

  logic [31:0] imem_addr, imem_data;
  logic        out_valid;
  logic [31:0] out_instr, out_pc;
  logic [2:0]  fq_count;

  logic [31:0] w_imem_addr, w_imem_data;
  logic        w_out_valid;
  logic [31:0] w_out_instr, w_out_pc;
  logic [2:0]  w_fq_count;
  logic        w_redirect_valid = 1'b0;
  logic [31:0] w_redirect_pc    = 32'h0;
  logic        w_out_ready      = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign imem_data   = 32'hA000_0000 + {2'b00, imem_addr[31:2]};
  assign w_imem_data = 32'hA000_0000 + {2'b00, w_imem_addr[31:2]};

  fetch_queue_unit u_dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fq_count       (fq_count)
  );

  fetch_queue_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (w_imem_addr),
    .imem_data      (w_imem_data),
    .redirect_valid (w_redirect_valid),
    .redirect_pc    (w_redirect_pc),
    .out_valid      (w_out_valid),
    .out_ready      (w_out_ready),
    .out_instr      (w_out_instr),
    .out_pc         (w_out_pc),
    .fq_count       (w_fq_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Outputs are checked on the falling edge, then inputs for the next rising
  // edge are driven right after.
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
    step(); step();

    // ---- Reset state ----
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(fq_count),  32'd0);
    check("rst_pc",    out_pc,         32'h0);
    check("rst_instr", out_instr,      32'h0);
    check("rst_addr",  imem_addr,      32'h0);
    rst = 1'b0;

    // ---- Free-run: one entry per cycle, count stays at 1 ----
    step();
    check("fr_valid0", 32'(out_valid), 32'd1);
    check("fr_pc0",    out_pc,         32'h0);
    check("fr_instr0", out_instr,      32'hA000_0000);
    check("fr_count0", 32'(fq_count),  32'd1);
    for (int i = 1; i <= 3; i++) begin
      step();
      check("fr_pc",    out_pc,        32'(4 * i));
      check("fr_instr", out_instr,     32'hA000_0000 + 32'(i));
      check("fr_count", 32'(fq_count), 32'd1);
    end

    // ---- Backpressure from reset: count saturates, PC holds ----
    rst = 1'b1; out_ready = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("bp_count", 32'(fq_count), 32'd4);
    check("bp_addr",  imem_addr,     32'h10);
    check("bp_pc",    out_pc,        32'h0);

    // ---- Full with simultaneous pop: pc 0 leaves, pc 0x10 enters ----
    out_ready = 1'b1;
    step();
    check("fp_count", 32'(fq_count), 32'd4);
    check("fp_pc",    out_pc,        32'h4);
    check("fp_addr",  imem_addr,     32'h14);
    // Drain continues in order with no loss or duplication.
    for (int i = 2; i <= 5; i++) begin
      step();
      check("dr_pc",    out_pc,    32'(4 * i));
      check("dr_instr", out_instr, 32'hA000_0000 + 32'(i));
    end

    // ---- Redirect with 3 entries queued ----
    rst = 1'b1; out_ready = 1'b0;
    step();
    rst = 1'b0;
    step(); step(); step();
    check("rd_count3", 32'(fq_count), 32'd3);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    check("rd_count", 32'(fq_count), 32'd0);
    check("rd_valid", 32'(out_valid), 32'd0);
    check("rd_addr",  imem_addr,      32'h100);
    check("rd_opc",   out_pc,         32'h0);
    redirect_valid = 1'b0; out_ready = 1'b1;
    step();
    check("rd_tgt_valid", 32'(out_valid), 32'd1);
    check("rd_tgt_pc",    out_pc,         32'h100);
    check("rd_tgt_instr", out_instr,      32'hA000_0040);

    // ---- Back-to-back redirects: last wins, nothing pushed ----
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    step();
    redirect_pc = 32'h302;
    step();
    check("b2b_count", 32'(fq_count), 32'd0);
    check("b2b_addr",  imem_addr,     32'h300);
    redirect_valid = 1'b0;
    step();
    check("b2b_pc",    out_pc,        32'h300);
    check("b2b_count1", 32'(fq_count), 32'd1);

    // ---- Reset during a full stall (reset also beats a redirect) ----
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("st_count", 32'(fq_count), 32'd4);
    check("st_addr",  imem_addr,     32'h310);
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h500;
    step();
    check("sr_count", 32'(fq_count),  32'd0);
    check("sr_valid", 32'(out_valid), 32'd0);
    check("sr_addr",  imem_addr,      32'h0);
    check("sr_pc",    out_pc,         32'h0);
    check("wr_addr0", w_imem_addr,    32'hFFFF_FFF8);
    rst = 1'b0; redirect_valid = 1'b0;

    // ---- Wrap-around instance: FFFF_FFF8, FFFF_FFFC, 0, 4 ----
    step();
    check("wr_pc0",    w_out_pc,    32'hFFFF_FFF8);
    check("wr_instr0", w_out_instr, 32'hDFFF_FFFE);
    step();
    check("wr_pc1",    w_out_pc,    32'hFFFF_FFFC);
    step();
    check("wr_pc2",    w_out_pc,    32'h0000_0000);
    check("wr_instr2", w_out_instr, 32'hA000_0000);
    step();
    check("wr_pc3",    w_out_pc,    32'h0000_0004);
    check("wr_count",  32'(w_fq_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
